usbdev_wake_tx: RTL and testbench

- Device-side generator of remote-wakeup resume signaling; the transmit counterpart to link-state detection, which only observes host-driven reset, suspend and resume.
- On a software request while the link is suspended, it waits until the bus has been idle (J) long enough, then drives K on D+/D- for a fixed duration and releases the bus.
- It sits between the usbdev register block and the PHY output mux. Its drive outputs take priority over the packet transmitter while wake_oe_o is high.

---
 rtl/usbdev_pkg.sv | 20 ++
 rtl/usbdev_us_timer.sv | 39 +++
 rtl/usbdev_wake_tx.sv | 134 +++++++++++++
 tb/tb_usbdev_wake_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usbdev_pkg.sv
// Shared types and constants for the usbdev remote-wakeup transmitter.
package usbdev_pkg;

  // Wake FSM encoding; also the value exposed for CSR readback.
  typedef enum logic [1:0] {
    WakeIdle     = 2'd0,
    WakeWaitIdle = 2'd1,
    WakeDrive    = 2'd2,
    WakeRelease  = 2'd3
  } wake_state_e;

  // Full-speed line patterns as {dp, dn}.
  localparam logic [1:0] USB_K = 2'b01;
  localparam logic [1:0] USB_J = 2'b10;

  // Legal K drive duration, in us.
  localparam int unsigned DRIVE_US_MIN = 1000;
  localparam int unsigned DRIVE_US_MAX = 15000;

endpackage

// File: rtl/usbdev_us_timer.sv
// Saturating microsecond counter with synchronous clear and a reached flag.
module usbdev_us_timer #(
  parameter int unsigned Width     = 14,
  // When set, reached reflects the count after this cycle's tick.
  parameter bit          Lookahead = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             tick,
  input  logic [Width-1:0] limit,
  output logic             reached
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear wins over tick; hold once the limit is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && tick && (cnt_q < limit)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign reached = Lookahead ? (cnt_d == limit) : (cnt_q == limit);

endmodule

// File: rtl/usbdev_wake_tx.sv
// Remote-wakeup resume generator: waits for enough suspend idle time,
// drives K for a fixed duration, then releases the bus.
module usbdev_wake_tx
  import usbdev_pkg::*;
#(
  parameter int unsigned MinIdleUs = 5000,
  parameter int unsigned DriveUs   = 2000,
  parameter int unsigned TimerW    = 14
) (
  input  logic       clk_48mhz_i,
  input  logic       rst_i,
  input  logic       us_tick_i,
  input  logic       wake_req_i,
  input  logic       link_suspend_i,
  input  logic       link_disconnect_i,
  input  logic       line_j_i,
  output logic       wake_oe_o,
  output logic       wake_dp_o,
  output logic       wake_dn_o,
  output logic       wake_busy_o,
  output logic       wake_done_o,
  output logic       wake_abort_o,
  output logic [1:0] wake_state_o
);

  localparam logic [1:0] StIdle     = WakeIdle;
  localparam logic [1:0] StWaitIdle = WakeWaitIdle;
  localparam logic [1:0] StDrive    = WakeDrive;
  localparam logic [1:0] StRelease  = WakeRelease;

  if (DriveUs < DRIVE_US_MIN || DriveUs > DRIVE_US_MAX) begin : gen_drive_range_err
    $error("usbdev_wake_tx: DriveUs out of legal range");
  end
  if ((1 << TimerW) <= MinIdleUs || (1 << TimerW) <= DriveUs) begin : gen_timer_w_err
    $error("usbdev_wake_tx: TimerW too narrow for MinIdleUs/DriveUs");
  end

  logic [1:0] state_q, state_d;
  logic       abort_q, abort_d;
  logic       idle_clear, idle_reached;
  logic       drive_active, drive_reached;

  // Idle time only accrues while suspended, line at J and we are not driving.
  assign idle_clear   = !(link_suspend_i && line_j_i && !wake_oe_o);
  assign drive_active = (state_q == StDrive);

  usbdev_us_timer #(
    .Width     (TimerW),
    .Lookahead (1'b0)
  ) u_idle_timer (
    .clk     (clk_48mhz_i),
    .rst     (rst_i),
    .clear   (idle_clear),
    .en      (1'b1),
    .tick    (us_tick_i),
    .limit   (TimerW'(MinIdleUs)),
    .reached (idle_reached)
  );

  // Held clear outside Drive, so the tick on the entry edge is not counted.
  // Lookahead lets the bus release right after the final counted tick.
  usbdev_us_timer #(
    .Width     (TimerW),
    .Lookahead (1'b1)
  ) u_drive_timer (
    .clk     (clk_48mhz_i),
    .rst     (rst_i),
    .clear   (!drive_active),
    .en      (drive_active),
    .tick    (us_tick_i),
    .limit   (TimerW'(DriveUs)),
    .reached (drive_reached)
  );

  // Next-state and abort pulse decode.
  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (wake_req_i) begin
          if (link_suspend_i && !link_disconnect_i) begin
            state_d = StWaitIdle;
          end else begin
            abort_d = 1'b1;
          end
        end
      end
      StWaitIdle: begin
        if (link_disconnect_i || !link_suspend_i) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (idle_reached) begin
          state_d = StDrive;
        end
      end
      StDrive: begin
        // Suspend and line state are our own K echo here, so only disconnect matters.
        if (link_disconnect_i) begin
          state_d = StIdle;
          abort_d = 1'b1;
        end else if (drive_reached) begin
          state_d = StRelease;
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM and abort pulse registers.
  always_ff @(posedge clk_48mhz_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
    end
  end

  assign wake_oe_o                = (state_q == StDrive);
  assign {wake_dp_o, wake_dn_o}   = wake_oe_o ? USB_K : USB_J;
  assign wake_busy_o              = (state_q != StIdle);
  assign wake_done_o              = (state_q == StRelease);
  assign wake_abort_o             = abort_q;
  assign wake_state_o             = state_q;

  a_oe_in_drive : assert property (@(posedge clk_48mhz_i) disable iff (rst_i)
    wake_oe_o |-> (wake_state_o == StDrive));
  a_done_abort_excl : assert property (@(posedge clk_48mhz_i) disable iff (rst_i)
    !(wake_done_o && wake_abort_o));

endmodule

// File: tb/tb_usbdev_wake_tx.sv
// Directed bench for usbdev_wake_tx: one task per scenario with inline checks.
module tb_usbdev_wake_tx;

  // Packed view: {oe, dp, dn, busy, done, abort, state[1:0]}
  localparam logic [7:0] IDLE_V  = 8'b0100_0000;
  localparam logic [7:0] WAIT_V  = 8'b0101_0001;
  localparam logic [7:0] DRIVE_V = 8'b1011_0010;
  localparam logic [7:0] REL_V   = 8'b0101_1011;
  localparam logic [7:0] ABORT_V = 8'b0100_0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       us_tick = 1'b0;
  logic       wake_req = 1'b0;
  logic       link_suspend = 1'b0;
  logic       link_disconnect = 1'b0;
  logic       line_j = 1'b0;
  logic       wake_oe, wake_dp, wake_dn, wake_busy, wake_done, wake_abort;
  logic [1:0] wake_state;
  logic [7:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  assign obs = {wake_oe, wake_dp, wake_dn, wake_busy, wake_done, wake_abort, wake_state};

  always #5 clk = ~clk;

  usbdev_wake_tx dut (
    .clk_48mhz_i       (clk),
    .rst_i             (rst),
    .us_tick_i         (us_tick),
    .wake_req_i        (wake_req),
    .link_suspend_i    (link_suspend),
    .link_disconnect_i (link_disconnect),
    .line_j_i          (line_j),
    .wake_oe_o         (wake_oe),
    .wake_dp_o         (wake_dp),
    .wake_dn_o         (wake_dn),
    .wake_busy_o       (wake_busy),
    .wake_done_o       (wake_done),
    .wake_abort_o      (wake_abort),
    .wake_state_o      (wake_state)
  );

  // n microseconds: tick high for one cycle, low for one cycle.
  task automatic tick_us(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); us_tick = 1'b1;
      @(negedge clk); us_tick = 1'b0;
    end
  endtask

  task automatic pulse_req();
    @(negedge clk); wake_req = 1'b1;
    @(negedge clk); wake_req = 1'b0;
  endtask

  // Drop suspend for one cycle to restart the idle counter from zero.
  task automatic restart_suspend();
    @(negedge clk); link_suspend = 1'b0;
    @(negedge clk); link_suspend = 1'b1; line_j = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++; $display("FAIL reset_state: got %b expected %b", obs, IDLE_V);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    int drv_bad;
    logic [7:0] rel_obs;
    n = 0; drv_bad = 0; rel_obs = '0;
    link_suspend = 1'b1; line_j = 1'b1;
    tick_us(6000);
    pulse_req();
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL nominal_waitidle: got %b expected %b", obs, WAIT_V);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== DRIVE_V) begin
      n_fail++; $display("FAIL nominal_drive_entry: got %b expected %b", obs, DRIVE_V);
    end
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (!wake_oe) break;
      if (obs !== DRIVE_V) drv_bad++;
      us_tick = 1'b1; n++;
      @(negedge clk); us_tick = 1'b0;
      if (!wake_oe) begin
        rel_obs = obs;
        break;
      end
    end
    n_checks++;
    if (n !== 2000) begin
      n_fail++; $display("FAIL nominal_k_ticks: got %0d expected %0d", n, 2000);
    end
    n_checks++;
    if (drv_bad !== 0) begin
      n_fail++; $display("FAIL nominal_k_pattern: got %0d bad cycles expected 0", drv_bad);
    end
    n_checks++;
    if (rel_obs !== REL_V) begin
      n_fail++; $display("FAIL nominal_release_done: got %b expected %b", rel_obs, REL_V);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++; $display("FAIL nominal_back_idle: got %b expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_early_request();
    restart_suspend();
    tick_us(1000);
    pulse_req();
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL early_waitidle: got %b expected %b", obs, WAIT_V);
    end
    tick_us(3999);
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL early_still_wait_4999: got %b expected %b", obs, WAIT_V);
    end
    tick_us(1);
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL early_wait_at_5000: got %b expected %b", obs, WAIT_V);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== DRIVE_V) begin
      n_fail++; $display("FAIL early_drive: got %b expected %b", obs, DRIVE_V);
    end
  endtask

  // Entered with the DUT in Drive.
  task automatic test_reset_in_drive();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++; $display("FAIL reset_in_drive: got %b expected %b", obs, IDLE_V);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_broken();
    restart_suspend();
    pulse_req();
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL broken_waitidle: got %b expected %b", obs, WAIT_V);
    end
    pulse_req();
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL req_while_busy_ignored: got %b expected %b", obs, WAIT_V);
    end
    tick_us(3000);
    line_j = 1'b0;
    tick_us(1);
    line_j = 1'b1;
    tick_us(4999);
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL broken_still_wait: got %b expected %b", obs, WAIT_V);
    end
    tick_us(1);
    @(negedge clk);
    n_checks++;
    if (obs !== DRIVE_V) begin
      n_fail++; $display("FAIL broken_drive_after_5000: got %b expected %b", obs, DRIVE_V);
    end
  endtask

  // Entered with the DUT in Drive and the drive timer at zero.
  task automatic test_disconnect_drive();
    tick_us(700);
    n_checks++;
    if (obs !== DRIVE_V) begin
      n_fail++; $display("FAIL disc_still_drive_700: got %b expected %b", obs, DRIVE_V);
    end
    link_disconnect = 1'b1;
    @(negedge clk); link_disconnect = 1'b0;
    n_checks++;
    if (obs !== ABORT_V) begin
      n_fail++; $display("FAIL disc_abort: got %b expected %b", obs, ABORT_V);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++; $display("FAIL disc_abort_single: got %b expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_host_resume();
    restart_suspend();
    pulse_req();
    tick_us(10);
    n_checks++;
    if (obs !== WAIT_V) begin
      n_fail++; $display("FAIL resume_waitidle: got %b expected %b", obs, WAIT_V);
    end
    link_suspend = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== ABORT_V) begin
      n_fail++; $display("FAIL resume_abort: got %b expected %b", obs, ABORT_V);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++; $display("FAIL resume_idle: got %b expected %b", obs, IDLE_V);
    end
  endtask

  task automatic test_reject();
    // Request coincident with suspend falling.
    @(negedge clk); link_suspend = 1'b1;
    @(negedge clk); link_suspend = 1'b0; wake_req = 1'b1;
    @(negedge clk); wake_req = 1'b0;
    n_checks++;
    if (obs !== ABORT_V) begin
      n_fail++; $display("FAIL reject_not_suspended: got %b expected %b", obs, ABORT_V);
    end
    @(negedge clk);
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++; $display("FAIL reject_single_pulse: got %b expected %b", obs, IDLE_V);
    end
    link_suspend = 1'b1; link_disconnect = 1'b1;
    pulse_req();
    n_checks++;
    if (obs !== ABORT_V) begin
      n_fail++; $display("FAIL reject_disconnected: got %b expected %b", obs, ABORT_V);
    end
    link_disconnect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== IDLE_V) begin
      n_fail++; $display("FAIL reject_disc_idle: got %b expected %b", obs, IDLE_V);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_early_request();
    test_reset_in_drive();
    test_idle_broken();
    test_disconnect_drive();
    test_host_resume();
    test_reject();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
